// File: rtl/spi_mon_pkg.sv
// Shared types for the SPI frame monitor: command encoding, FSM states and
// the command field width.
package spi_mon_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    CMD,
    PAYLOAD,
    GAP,
    TX,
    END,
    OVERRUN
  } state_e;

  localparam int CMD_BITS = 2;

endpackage

// File: rtl/spi_mon_sat_cnt.sv
// Up-counter that sticks at all-ones instead of wrapping.
module spi_mon_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/spi_frame_monitor.sv
// Passive SPI slave-side frame monitor: decodes command/payload/read-data,
// checks frame length, MISO idle level and read ordering.
module spi_frame_monitor
  import spi_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int READ_GAP   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  input  logic                  MISO,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [1:0]            frame_cmd,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_seq,
  output logic                  err_miso,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  // Bit counter wide enough for both a payload and the longest gap.
  localparam int CW = $clog2(DATA_WIDTH + 16);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] pay_q, pay_d, rx_q, rx_d;
  logic                  seen_q, seen_d;
  logic                  done_q, done_d, ok_q, ok_d;
  logic                  short_q, short_d, long_q, long_d;
  logic                  seq_q, seq_d, miso_q, miso_d;
  logic [CMD_BITS-1:0]   fcmd_q, fcmd_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d, rdd_q, rdd_d;
  logic                  complete, exact, is_rd;

  // The state names the phase the next low sample belongs to; CHK and CMD
  // each absorb one command bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    pay_d    = pay_q;
    rx_d     = rx_q;
    seen_d   = seen_q;
    fcmd_d   = fcmd_q;
    fdata_d  = fdata_q;
    rdd_d    = rdd_q;
    done_d   = 1'b0;
    ok_d     = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    seq_d    = 1'b0;
    complete = 1'b0;
    exact    = 1'b0;
    is_rd    = (cmd_q == CMD_RD_DATA);
    miso_d   = MISO && !((state_q == TX) && !SS_n);

    case (state_q)
      IDLE: if (!SS_n) state_d = CHK;
      CHK, CMD: begin
        if (SS_n) short_d = 1'b1;
        else begin
          cmd_d   = {cmd_q[CMD_BITS-2:0], MOSI};
          state_d = (state_q == CHK) ? CMD : PAYLOAD;
          cnt_d   = '0;
        end
      end
      PAYLOAD: begin
        if (SS_n) short_d = 1'b1;
        else begin
          pay_d = {pay_q[DATA_WIDTH-2:0], MOSI};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d = '0;
            if (!is_rd)            state_d = END;
            else if (READ_GAP > 0) state_d = GAP;
            else                   state_d = TX;
          end
        end
      end
      GAP: begin
        if (SS_n) short_d = 1'b1;
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(READ_GAP - 1)) begin
            cnt_d   = '0;
            state_d = TX;
          end
        end
      end
      TX: begin
        if (SS_n) short_d = 1'b1;
        else begin
          rx_d  = {rx_q[DATA_WIDTH-2:0], MISO};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = END;
          end
        end
      end
      END: begin
        if (SS_n) begin
          complete = 1'b1;
          exact    = 1'b1;
        end else begin
          state_d = OVERRUN;
          long_d  = 1'b1;
        end
      end
      OVERRUN: if (SS_n) complete = 1'b1;
      default: state_d = IDLE;
    endcase

    if (short_d) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end

    // Full-length frames (exact or overrun) publish their decode.
    if (complete) begin
      state_d = IDLE;
      done_d  = 1'b1;
      fcmd_d  = cmd_q;
      fdata_d = pay_q;
      seq_d   = is_rd && !seen_q;
      ok_d    = exact && !seq_d;
      if (is_rd) seen_d = 1'b0;
      if (ok_d && (cmd_q == CMD_RD_ADDR)) seen_d = 1'b1;
      if (ok_d && is_rd) rdd_d = rx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      seq_q   <= 1'b0;
      miso_q  <= 1'b0;
      fcmd_q  <= '0;
      fdata_q <= '0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      short_q <= short_d;
      long_q  <= long_d;
      seq_q   <= seq_d;
      miso_q  <= miso_d;
      fcmd_q  <= fcmd_d;
      fdata_q <= fdata_d;
      rdd_q   <= rdd_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
    pay_q <= pay_d;
    rx_q  <= rx_d;
  end

  // Counters take the next-cycle pulse values so they move with the outputs.
  spi_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_d && ok_d),
    .count (frame_cnt)
  );

  spi_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (short_d || long_d || seq_d || miso_d),
    .count (err_cnt)
  );

  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign frame_cmd  = fcmd_q;
  assign frame_data = fdata_q;
  assign rd_data    = rdd_q;
  assign err_short  = short_q;
  assign err_long   = long_q;
  assign err_seq    = seq_q;
  assign err_miso   = miso_q;

endmodule
